// File: rtl/monocular_pkg.sv
// Shared types for the logic-analyser capture path: FIFO entry layout and
// the byte-serializer state encoding.
package monocular_pkg;

    localparam int TS_WIDTH     = 16;
    localparam int SAMPLE_WIDTH = 8;
    localparam int ENTRY_WIDTH  = SAMPLE_WIDTH + TS_WIDTH;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] value;
        logic [TS_WIDTH-1:0]     ts;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } ser_state_t;

endpackage

// File: rtl/pin_change_capture_if.sv
// Byte stream toward the SPI slave. out_byte is transferred on a CLK edge where
// out_valid && out_ready; once out_valid rises, out_byte/out_valid hold until then.
interface pin_change_capture_if;
    import monocular_pkg::*;

    logic [SAMPLE_WIDTH-1:0] out_byte;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output out_byte, output out_valid, input out_ready);
    modport slave  (input out_byte, input out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level. Pushes are refused when full, even
// if a pop happens in the same cycle; pops are refused when empty.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 64
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/pin_change_capture.sv
// Synchronises the probe pins, records (value, delta-time) entries on change,
// enable rising or timestamp keepalive, and streams each entry as 3 bytes.
module pin_change_capture
    import monocular_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int TS_MAX = 65535
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [SAMPLE_WIDTH-1:0]   pin_values,
    input  logic                      enable,
    pin_change_capture_if.master      bus,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output ser_state_t                o_dbg_state
);

    localparam logic [TS_WIDTH-1:0] TS_MAX_L = TS_WIDTH'(TS_MAX);

    logic [SAMPLE_WIDTH-1:0] r_s1;
    logic [SAMPLE_WIDTH-1:0] r_s2;
    logic [SAMPLE_WIDTH-1:0] r_prev;
    logic                    r_en_d;
    logic [TS_WIDTH-1:0]     r_ts;
    logic                    r_overflow;
    ser_state_t              r_state;
    ser_state_t              w_state_next;
    entry_t                  r_frame;

    logic                    w_rise;
    logic                    w_change;
    logic                    w_keep;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    entry_t                  w_entry;
    logic [ENTRY_WIDTH-1:0]  w_fifo_rdata;
    logic [SAMPLE_WIDTH-1:0] w_byte;

    assign w_rise   = enable && !r_en_d;
    assign w_change = enable && (r_s2 != r_prev);
    assign w_keep   = enable && (r_ts == TS_MAX_L);
    assign w_push   = w_rise || w_change || w_keep;

    // A keepalive without a change has s2 == prev and ts == TS_MAX, so the
    // change form {s2, ts} already encodes it.
    assign w_entry.value = r_s2;
    assign w_entry.ts    = w_rise ? '0 : r_ts;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_prev     <= '0;
            r_en_d     <= 1'b0;
            r_ts       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_s1   <= pin_values;
            r_s2   <= r_s1;
            r_en_d <= enable;
            if (!enable)     r_ts <= '0;
            else if (w_push) r_ts <= TS_WIDTH'(1);
            else             r_ts <= r_ts + 1'b1;
            if (!enable || w_push) r_prev <= r_s2;
            // A dropped push wins over the clear on an enable rising edge.
            if (w_push && w_full) r_overflow <= 1'b1;
            else if (w_rise)      r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_frame <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) r_frame <= w_fifo_rdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_byte       = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = B0;
                end
            end
            B0: begin
                w_byte = r_frame.value;
                if (bus.out_ready) w_state_next = B1;
            end
            B1: begin
                w_byte = r_frame.ts[15:8];
                if (bus.out_ready) w_state_next = B2;
            end
            B2: begin
                w_byte = r_frame.ts[7:0];
                if (bus.out_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = B0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.out_byte  = w_byte;
    assign bus.out_valid = (r_state != IDLE);
    assign overflow      = r_overflow;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/pin_change_capture.md
Name: pin_change_capture

Overview:
Capture stage between the eight probe inputs and the SPI byte transmitter of the logic analyser.
- Synchronises pin_values and detects changes.
- Records each change as a (value, timestamp-delta) entry in a FIFO.
- Serialises each entry into a 3-byte frame on a valid/ready byte stream consumed by the SPI slave.
- Periodic keepalive entries keep timestamps unambiguous when the pins are idle.

Parameters:
- DEPTH, 64, FIFO entries. Power of two, at least 4.
- TS_MAX, 65535, keepalive threshold in CLK cycles. At most 2^16-1.

Ports:
- CLK  in  1  system clock, 16 MHz.
- reset  in  1  synchronous, active-high.
- pin_values  in  8  asynchronous probe inputs.
- enable  in  1  capture enable.
- out_byte  out  8  frame byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- overflow  out  1  sticky: an entry was dropped.
- fifo_level  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (reset, synchronous, active-high; clock CLK): all outputs 0, FIFO emptied, synchronisers/prev/counter cleared, serializer to IDLE. Reset mid-frame abandons the frame; no partial bytes follow.
- Synchroniser: 2 flops (s1, s2). prev holds the last recorded value, 8 bits.
- Counter ts, 16-bit:
  - Held 0 while enable=0.
  - Otherwise +1 per cycle.
  - Set to 1 in any cycle a push occurs (including dropped pushes).
- Push conditions, evaluated only when enable=1:
  - enable rising (registered edge): push {s2, ts=0}; clear overflow.
  - s2 != prev: push {s2, ts}.
  - ts == TS_MAX with no change: keepalive push {prev, TS_MAX}.
  - Change and TS_MAX in the same cycle: one entry, change form.
  - prev <= s2 whenever a push condition occurs, and continuously while enable=0.
- Latency: a pin change sampled at edge t is written at edge t+2; fifo_level reflects it after edge t+2.
- FIFO full: push dropped, overflow<=1 (sticky until reset or enable rising). Full blocks push even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves fifo_level unchanged.
- Serializer states IDLE, B0, B1, B2:
  - IDLE with FIFO non-empty: pop the entry into a 24-bit frame register, go to B0. out_valid=1 from the next cycle.
  - B0 sends value; B1 sends ts[15:8]; B2 sends ts[7:0].
  - Advance on out_valid && out_ready.
  - B2 handshake: if the FIFO is non-empty, pop and go to B0 with no bubble; otherwise go to IDLE with out_valid=0.
  - While out_ready=0, out_byte and out_valid are held stable.
- enable falling does not flush: queued entries still drain.
- FIFO pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.

Decomposition:
- Package monocular_pkg:
  - TS_WIDTH=16, SAMPLE_WIDTH=8, ENTRY_WIDTH=24.
  - Entry struct {value, ts}.
  - Serializer state enum {IDLE, B0, B1, B2}.
- Sub-module sync_fifo:
  - Parameterised width and depth.
  - push, pop, full, empty, level; single clock.
  - Reusable by the SPI slave receive path.
- Synchroniser, change detect, counter and serializer stay in pin_change_capture.

Test Plan:
1. pins=0xA5, enable 0→1, out_ready=1 → bytes A5,00,00 then out_valid=0; overflow=0.
2. After test 1, pins→0x5A exactly 10 cycles after the snapshot push → bytes 5A,00,0A.
3. Pins static 65535 cycles after a push → keepalive bytes A5,FF,FF; fifo_level returns to 0.
4. Frame pending, out_ready=0 for 20 cycles → out_byte=value and out_valid=1 held for all 20; frame completes in 3 handshakes after release.
5. out_ready=0 with DEPTH+3 pin toggles → fifo_level=DEPTH, overflow=1, the first DEPTH entries drain intact. A following enable 0→1 clears overflow.
6. reset asserted during B1 → out_valid=0 next cycle, fifo_level=0, no B2 byte ever emitted; test 1 repeated afterwards passes.
